palette_ctrl: RTL and testbench

Owns the two-bank 64-entry x 15-bit NES palette RAM and schedules access to its single port. Pixel lookups come from the video path and host palette uploads arrive as a byte stream from the SPI/user_io download path. Pixel lookups have priority. Upload writes are buffered and committed in idle cycles, with a starvation guard that forces a commit. Sits between the PPU colour index and the scandoubler/Hq2x input.

---
 rtl/palette_ctrl.sv | 151 +++++++++++++++
 tb/tb_palette_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_ctrl.sv
// Palette RAM owner: two 64x15 banks on one port, pixel lookups first,
// host uploads buffered and committed in idle cycles or forced after a wait.
module palette_ctrl #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_req,
  input  logic [5:0]  color,
  input  logic        bank,
  output logic [14:0] pixel,
  output logic        pixel_valid,
  input  logic        load_start,
  input  logic        load_bank,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  output logic        busy,
  output logic        load_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic        bank_q, bank_d;
  logic [7:0]  lo_q, lo_d;
  logic [14:0] entry_q, entry_d;
  logic [14:0] pixel_q;
  logic        pvalid_q;

  logic [14:0] mem [0:127];

  logic in_commit;
  logic force_wr;
  logic wr_en;
  logic rd_en;
  logic accept;

  assign in_commit = (state_q == S_COMMIT);
  assign force_wr  = pix_req && (int'(wait_q) >= MAX_WAIT);
  assign wr_en     = in_commit && !load_start && (!pix_req || force_wr);
  // a write only shares a cycle with pix_req when forced; the lookup is dropped
  assign rd_en     = pix_req && !wr_en;

  assign dl_ready  = (state_q == S_LO) || (state_q == S_HI);
  assign accept    = dl_ready && dl_valid;
  assign busy      = (state_q == S_LO) || (state_q == S_HI) || in_commit;
  assign load_done = (state_q == S_DONE);

  assign pixel       = pixel_q;
  assign pixel_valid = pvalid_q;

  // Upload sequencing: byte assembly, commit scheduling, abort on restart
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    bank_d  = bank_q;
    lo_d    = lo_q;
    entry_d = entry_q;
    unique case (state_q)
      S_IDLE: begin
      end
      S_LO: begin
        if (accept) begin
          lo_d    = dl_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          entry_d = {dl_data[6:0], lo_q};
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (wr_en) begin
          wait_d = 8'd0;
          if (idx_q == 6'd63) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_LO;
          end
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_start) begin
      state_d = S_LO;
      bank_d  = load_bank;
      idx_d   = 6'd0;
      wait_d  = 8'd0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      wait_q  <= 8'd0;
      bank_q  <= 1'b0;
      lo_q    <= 8'd0;
      entry_q <= 15'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      bank_q  <= bank_d;
      lo_q    <= lo_d;
      entry_q <= entry_d;
    end
  end

  // Palette RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{bank_q, idx_q}] <= entry_q;
    end
  end

  // Registered lookup; pixel holds when no lookup issues
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_q  <= 15'd0;
      pvalid_q <= 1'b0;
    end else begin
      pvalid_q <= rd_en;
      if (rd_en) begin
        pixel_q <= mem[{bank, color}];
      end
    end
  end

endmodule

// File: tb/tb_palette_ctrl.sv
// Bench for palette_ctrl: directed scenarios with literal expectations
// plus randomized traffic against a transaction-level palette model.
module tb_palette_ctrl;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_req = 1'b0;
  logic [5:0]  color = 6'd0;
  logic        bank = 1'b0;
  logic        load_start = 1'b0;
  logic        load_bank = 1'b0;
  logic        dl_valid = 1'b0;
  logic [7:0]  dl_data = 8'd0;
  logic [14:0] pixel;
  logic        pixel_valid;
  logic        dl_ready;
  logic        busy;
  logic        load_done;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int done_seen = 0;

  palette_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pix_req(pix_req),
    .color(color),
    .bank(bank),
    .pixel(pixel),
    .pixel_valid(pixel_valid),
    .load_start(load_start),
    .load_bank(load_bank),
    .dl_valid(dl_valid),
    .dl_data(dl_data),
    .dl_ready(dl_ready),
    .busy(busy),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  // model: palette contents, upload progress, expected outputs
  logic [14:0] m_ram [128];
  bit          m_ok  [128];
  bit          m_active, m_have_lo, m_pend, m_done, m_pv, m_pix_ok, m_acc;
  logic [5:0]  m_idx;
  logic        m_bank;
  logic [7:0]  m_lo;
  logic [14:0] m_entry, m_pix;
  int          m_wait;

  logic [7:0] lo_tab [64];
  logic [7:0] hi_tab [64];

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk15(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active  = 0;
    m_have_lo = 0;
    m_pend    = 0;
    m_done    = 0;
    m_pv      = 0;
    m_pix     = 15'd0;
    m_pix_ok  = 1;
    m_wait    = 0;
    m_idx     = 6'd0;
    m_acc     = 0;
  endfunction

  function automatic void model_step();
    bit wr;
    bit lk;
    if (!reset_n) begin
      model_reset();
      return;
    end
    wr = m_pend && !load_start && (!pix_req || m_wait >= MAXW);
    lk = pix_req && !wr;
    m_acc = m_active && !m_pend && dl_valid;
    m_pv = lk;
    if (lk) begin
      m_pix    = m_ram[{bank, color}];
      m_pix_ok = m_ok[{bank, color}];
    end
    m_done = 0;
    if (wr) begin
      m_ram[{m_bank, m_idx}] = m_entry;
      m_ok[{m_bank, m_idx}]  = 1;
    end
    if (load_start) begin
      m_active  = 1;
      m_bank    = load_bank;
      m_idx     = 6'd0;
      m_pend    = 0;
      m_have_lo = 0;
      m_wait    = 0;
    end else if (wr) begin
      m_pend = 0;
      m_wait = 0;
      if (m_idx == 6'd63) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_idx = m_idx + 6'd1;
      end
    end else if (m_pend) begin
      m_wait = (m_wait < 255) ? m_wait + 1 : 255;
    end else if (m_acc) begin
      if (!m_have_lo) begin
        m_lo      = dl_data;
        m_have_lo = 1;
      end else begin
        m_entry   = {dl_data[6:0], m_lo};
        m_have_lo = 0;
        m_pend    = 1;
      end
    end
  endfunction

  task automatic cmp_model();
    chk1("pixel_valid", pixel_valid, m_pv);
    chk1("dl_ready", dl_ready, m_active && !m_pend);
    chk1("busy", busy, m_active);
    chk1("load_done", load_done, m_done);
    if (m_pix_ok) chk15("pixel", pixel, m_pix);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    ncyc++;
    cmp_model();
    if (load_done === 1'b1) done_seen++;
  endtask

  task automatic send_byte(logic [7:0] b);
    dl_valid = 1'b1;
    dl_data  = b;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (m_acc) break;
    end
    dl_valid = 1'b0;
  endtask

  task automatic write_entry(logic [7:0] lo, logic [7:0] hi);
    send_byte(lo);
    send_byte(hi);
    pix_req = 1'b0;
    cycle();
  endtask

  task automatic upload(logic b);
    int n0;
    int d0;
    load_start = 1'b1;
    load_bank  = b;
    n0 = ncyc;
    d0 = done_seen;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < 64; i++) write_entry(lo_tab[i], hi_tab[i]);
    chk1("done_pulse", load_done, 1'b1);
    chk1("done_not_busy", busy, 1'b0);
    chkn("upload_cycles", ncyc - n0, 193);
    cycle();
    chk1("done_clears", load_done, 1'b0);
    chkn("done_count", done_seen - d0, 1);
  endtask

  task automatic look_chk(string name, logic b, logic [5:0] c,
                          logic [14:0] exp);
    pix_req = 1'b1;
    bank    = b;
    color   = c;
    cycle();
    pix_req = 1'b0;
    chk15(name, pixel, exp);
    chk1({name, "_valid"}, pixel_valid, 1'b1);
  endtask

  task automatic starve(string name, logic [7:0] lo, logic [7:0] hi);
    int zeros;
    int zpos;
    send_byte(lo);
    send_byte(hi);
    zeros = 0;
    zpos  = 0;
    for (int j = 1; j <= 12; j++) begin
      pix_req = 1'b1;
      bank    = 1'($urandom);
      color   = 6'($urandom);
      cycle();
      if (pixel_valid !== 1'b1) begin
        zeros++;
        zpos = j;
      end
    end
    pix_req = 1'b0;
    chkn({name, "_gaps"}, zeros, 1);
    chkn({name, "_gap_pos"}, zpos, MAXW + 1);
  endtask

  initial begin
    int mode;
    for (int i = 0; i < 128; i++) m_ok[i] = 0;
    model_reset();

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk15("rst_pixel", pixel, 15'd0);
    chk1("rst_pv", pixel_valid, 1'b0);
    chk1("rst_ready", dl_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", load_done, 1'b0);
    reset_n = 1'b1;
    cycle();

    // bank 1: high-byte bit 7 set everywhere, entry 5 is 0xFF,0xFF
    for (int i = 0; i < 64; i++) begin
      lo_tab[i] = 8'(i);
      hi_tab[i] = 8'h80 | 8'(i);
    end
    lo_tab[5] = 8'hFF;
    hi_tab[5] = 8'hFF;
    upload(1'b1);
    look_chk("b1_idx5", 1'b1, 6'd5, 15'h7FFF);
    look_chk("b1_idx10", 1'b1, 6'd10, 15'h0A0A);
    look_chk("b1_idx63", 1'b1, 6'd63, 15'h3F3F);

    // bank 0: random contents, entry 0x16 = 0x001F
    for (int i = 0; i < 64; i++) begin
      lo_tab[i] = 8'($urandom);
      hi_tab[i] = 8'($urandom);
    end
    lo_tab[22] = 8'h1F;
    hi_tab[22] = 8'h00;
    upload(1'b0);
    look_chk("lookup_16", 1'b0, 6'h16, 15'h001F);
    cycle();
    chk1("pv_gap", pixel_valid, 1'b0);
    chk15("pixel_held", pixel, 15'h001F);

    // starvation, then idle commit, then starvation again
    load_start = 1'b1;
    load_bank  = 1'b0;
    cycle();
    load_start = 1'b0;
    starve("starve0", 8'h34, 8'h12);
    send_byte(8'h78);
    send_byte(8'h56);
    pix_req = 1'b1;
    cycle();
    chk1("idle_wait1", dl_ready, 1'b0);
    cycle();
    chk1("idle_wait2", dl_ready, 1'b0);
    pix_req = 1'b0;
    cycle();
    chk1("idle_commit", dl_ready, 1'b1);
    starve("starve1", 8'h9A, 8'h3C);
    look_chk("st_idx0", 1'b0, 6'd0, 15'h1234);
    look_chk("st_idx1", 1'b0, 6'd1, 15'h5678);
    look_chk("st_idx2", 1'b0, 6'd2, 15'h3C9A);

    // abort at index 10 of a bank 1 upload
    load_start = 1'b1;
    load_bank  = 1'b1;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) write_entry(8'h40 + 8'(i), 8'h20);
    send_byte(8'hAA);
    send_byte(8'h2B);
    pix_req = 1'b1;
    cycle();
    pix_req    = 1'b0;
    load_start = 1'b1;
    load_bank  = 1'b0;
    cycle();
    load_start = 1'b0;
    chk1("abort_ready", dl_ready, 1'b1);
    chk1("abort_busy", busy, 1'b1);
    look_chk("abort_idx10", 1'b1, 6'd10, 15'h0A0A);
    look_chk("abort_idx9", 1'b1, 6'd9, 15'h2049);

    // reset while in HI after entry 5 of the bank 0 upload
    for (int i = 0; i < 5; i++) write_entry(8'hA0 + 8'(i), 8'h50);
    send_byte(8'hEE);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk15("mid_rst_pixel", pixel, 15'd0);
    chk1("mid_rst_pv", pixel_valid, 1'b0);
    chk1("mid_rst_ready", dl_ready, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", load_done, 1'b0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    chk1("post_rst_ready", dl_ready, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++)
      look_chk("kept_entry", 1'b0, 6'(i), 15'h50A0 + 15'(i));

    // randomized traffic: blanking, mixed and saturated lookup phases
    mode = 0;
    for (int n = 0; n < 15000; n++) begin
      if (n % 64 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       pix_req = 1'b0;
        1:       pix_req = ($urandom % 4) != 0;
        default: pix_req = 1'b1;
      endcase
      color      = 6'($urandom);
      bank       = 1'($urandom);
      load_bank  = 1'($urandom);
      load_start = m_active ? (($urandom % 2000) == 0)
                            : (($urandom % 40) == 0);
      dl_valid   = ($urandom % 3) != 0;
      dl_data    = 8'($urandom);
      cycle();
    end
    load_start = 1'b0;
    pix_req    = 1'b0;
    dl_valid   = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
